// File: rtl/hook_ctrl_if.sv
// hook_ctrl_if: bundles the signals between the fishing-line controller and
// its surroundings.
//   Inputs to the controller:
//     mouse_valid / mouse_dy  decoded mouse packet (dy > 0 means up)
//     btn_left / btn_right    button levels
//     bait_avail              inventory holds at least one bait
//     bite                    fish touched the baited hook (pulse)
//     frame_tick              one pulse per VGA frame
//   Outputs from the controller:
//     mode / mouse_v          sprite mode and hook height (0.1 px units)
//     bait_used / caught      single-cycle event pulses
//   modport slave  : the controller side
//   modport master : the environment side (drives the inputs)
interface hook_ctrl_if;
  logic        mouse_valid;
  logic [8:0]  mouse_dy;
  logic        btn_left;
  logic        btn_right;
  logic        bait_avail;
  logic        bite;
  logic        frame_tick;
  logic [1:0]  mode;
  logic [13:0] mouse_v;
  logic        bait_used;
  logic        caught;

  modport slave (
    input  mouse_valid, mouse_dy, btn_left, btn_right, bait_avail, bite, frame_tick,
    output mode, mouse_v, bait_used, caught
  );

  modport master (
    output mouse_valid, mouse_dy, btn_left, btn_right, bait_avail, bite, frame_tick,
    input  mode, mouse_v, bait_used, caught
  );
endinterface

// File: rtl/hook_ctrl.sv
// hook_ctrl: owns the hook state (no hook / bare / baited / reeling) and the
// hook height in tenths of a pixel. Tracks the mouse while a hook is out,
// consumes bait on a right click, and reels the hook up automatically after a
// bite, reporting the catch when the hook reaches the rest position.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : hook_ctrl_if.slave (mouse, buttons, bite, frame tick in;
//          mode, mouse_v, bait_used, caught out, all registered)
module hook_ctrl #(
  parameter logic [13:0] V_MIN     = 14'd620,
  parameter logic [13:0] V_MAX     = 14'd4700,
  parameter logic [13:0] REEL_STEP = 14'd40
) (
  input  logic        clk,
  input  logic        rst,
  hook_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOOK   = 2'd1;
  localparam logic [1:0] BAITED = 2'd2;
  localparam logic [1:0] REEL   = 2'd3;

  logic [1:0]  state_r;
  logic [13:0] mouse_v_r;
  logic        btn_left_q_r;
  logic        btn_right_q_r;
  logic        bait_used_r;
  logic        caught_r;

  logic [1:0]  state_s;
  logic [13:0] mouse_v_s;
  logic        bait_used_s;
  logic        caught_s;
  logic        lrise_s;
  logic        rrise_s;

  // Apply a mouse delta to a height. Done in 16-bit signed so a large upward
  // move near the top or a downward move near the bottom cannot wrap before
  // the clamp sees it.
  function automatic logic [13:0] track(input logic [13:0] v, input logic [8:0] dy);
    logic signed [15:0] t;
    t = $signed({2'b00, v}) - $signed({{7{dy[8]}}, dy});
    if (t < $signed({2'b00, V_MIN})) begin
      track = V_MIN;
    end else if (t > $signed({2'b00, V_MAX})) begin
      track = V_MAX;
    end else begin
      track = t[13:0];
    end
  endfunction

  assign lrise_s = bus.btn_left  & ~btn_left_q_r;
  assign rrise_s = bus.btn_right & ~btn_right_q_r;

  // Next-state, next-height and event-pulse decode.
  always_comb begin
    state_s     = state_r;
    mouse_v_s   = mouse_v_r;
    bait_used_s = 1'b0;
    caught_s    = 1'b0;
    case (state_r)
      IDLE: begin
        mouse_v_s = V_MIN;
        if (lrise_s) begin
          state_s = HOOK;
        end else begin
          state_s = IDLE;
        end
      end
      HOOK: begin
        if (lrise_s) begin
          state_s = IDLE;
        end else if (rrise_s && bus.bait_avail) begin
          state_s     = BAITED;
          bait_used_s = 1'b1;
        end else begin
          state_s = HOOK;
        end
      end
      BAITED: begin
        // A bite in the same cycle as a left click still lands the fish.
        if (bus.bite) begin
          state_s = REEL;
        end else if (lrise_s) begin
          state_s = IDLE;
        end else begin
          state_s = BAITED;
        end
      end
      REEL: begin
        if (bus.frame_tick) begin
          if (mouse_v_r == V_MIN) begin
            caught_s = 1'b1;
            state_s  = IDLE;
          end else if ((mouse_v_r - V_MIN) <= REEL_STEP) begin
            mouse_v_s = V_MIN;
          end else begin
            mouse_v_s = mouse_v_r - REEL_STEP;
          end
        end else begin
          state_s = REEL;
        end
      end
      default: begin
        state_s   = IDLE;
        mouse_v_s = V_MIN;
      end
    endcase

    // Mouse tracking while a hook is out and stays out; a bait pickup in the
    // same cycle does not swallow the packet.
    if (((state_r == HOOK) || (state_r == BAITED)) && (state_s != IDLE) && bus.mouse_valid) begin
      mouse_v_s = track(mouse_v_r, bus.mouse_dy);
    end else if (state_s == IDLE) begin
      mouse_v_s = V_MIN;
    end else begin
      mouse_v_s = mouse_v_s;
    end
  end

  // State, height, button history and output pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      mouse_v_r     <= V_MIN;
      btn_left_q_r  <= 1'b0;
      btn_right_q_r <= 1'b0;
      bait_used_r   <= 1'b0;
      caught_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      mouse_v_r     <= mouse_v_s;
      btn_left_q_r  <= bus.btn_left;
      btn_right_q_r <= bus.btn_right;
      bait_used_r   <= bait_used_s;
      caught_r      <= caught_s;
    end
  end

  assign bus.mode      = state_r;
  assign bus.mouse_v   = mouse_v_r;
  assign bus.bait_used = bait_used_r;
  assign bus.caught    = caught_r;

endmodule

// File: tb/tb_hook_ctrl.sv
// tb_hook_ctrl: self-checking bench for hook_ctrl. A directed vector table,
// hand-written multi-cycle sequences, and a randomized run, all checked
// against an integer-arithmetic reference model of the hook rules.
module tb_hook_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              mv = 1'b0;
  logic signed [8:0] dy = 9'sd0;
  logic              bl = 1'b0;
  logic              br = 1'b0;
  logic              bait = 1'b0;
  logic              bite = 1'b0;
  logic              tick = 1'b0;

  hook_ctrl_if bus ();
  assign bus.mouse_valid = mv;
  assign bus.mouse_dy    = dy;
  assign bus.btn_left    = bl;
  assign bus.btn_right   = br;
  assign bus.bait_avail  = bait;
  assign bus.bite        = bite;
  assign bus.frame_tick  = tick;

  hook_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_mode = 0;
  int m_v = 620;
  int m_bu = 0;
  int m_ca = 0;
  bit m_pl = 1'b0;
  bit m_pr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hook rules in plain integer form.
  task automatic model_step();
    int nm, nv, nbu, nca;
    bit lr, rr;
    if (rst) begin
      nm = 0; nv = 620; nbu = 0; nca = 0;
      m_pl = 1'b0; m_pr = 1'b0;
    end else begin
      lr = bl && !m_pl;
      rr = br && !m_pr;
      nm = m_mode; nv = m_v; nbu = 0; nca = 0;
      if (m_mode == 0) begin
        if (lr) nm = 1;
      end else if (m_mode == 3) begin
        if (tick) begin
          if (m_v == 620) begin
            nca = 1; nm = 0;
          end else begin
            nv = (m_v - 40 < 620) ? 620 : m_v - 40;
          end
        end
      end else begin
        if (m_mode == 2 && bite) nm = 3;
        else if (lr) nm = 0;
        else if (m_mode == 1 && rr && bait) begin
          nm = 2; nbu = 1;
        end
        if (nm != 0 && mv) begin
          nv = m_v - int'(dy);
          if (nv < 620) nv = 620;
          if (nv > 4700) nv = 4700;
        end
      end
      if (nm == 0) nv = 620;
      m_pl = bl; m_pr = br;
    end
    m_mode = nm; m_v = nv; m_bu = nbu; m_ca = nca;
  endtask

  // One clock: advance the model, then check the DUT against it.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("model_mode", int'(bus.mode), m_mode);
    chk("model_v", int'(bus.mouse_v), m_v);
    chk("model_bait_used", int'(bus.bait_used), m_bu);
    chk("model_caught", int'(bus.caught), m_ca);
  endtask

  task automatic quiet();
    rst = 1'b0; mv = 1'b0; dy = 9'sd0; bl = 1'b0; br = 1'b0;
    bite = 1'b0; tick = 1'b0;
  endtask

  // Reset, cast, descend to target, bait.
  task automatic goto_baited(input int target);
    int rem, d;
    quiet(); rst = 1'b1; cycle();
    quiet(); bl = 1'b1; cycle();
    quiet();
    rem = target - 620;
    while (rem > 0) begin
      d = (rem > 255) ? 255 : rem;
      mv = 1'b1; dy = 9'(-d);
      cycle();
      rem -= d;
    end
    quiet(); br = 1'b1; bait = 1'b1; cycle();
    quiet(); cycle();
    chk("setup_mode", int'(bus.mode), 2);
    chk("setup_v", int'(bus.mouse_v), target);
  endtask

  typedef struct {
    bit rst, mv, bl, br, bait, bite, tick;
    int dy;
    int e_mode, e_v, e_bu, e_ca;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int peak, ev;
    //           rst mv bl br bt bi tk  dy    mode v    bu ca
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,    0,  0, 620, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0,    0,  1, 620, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, -100,  1, 720, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 0, 0,    0,  1, 720, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 0,    0,  1, 720, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 1, 0, 0,    0,  2, 720, 1, 0};
    tbl[6]  = '{0, 0, 0, 1, 1, 0, 0,    0,  2, 720, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 1, 0, 0,  255,  2, 620, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 0, 1,    0,  2, 620, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 1, 1, 0,    0,  3, 620, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 1,    0,  0, 620, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 1, 0, 0,    0,  0, 620, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 1, 0, 0, -100,  0, 620, 0, 0};
    tbl[13] = '{0, 0, 1, 0, 1, 0, 0,    0,  1, 620, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 1, 1, 1,    0,  1, 620, 0, 0};
    tbl[15] = '{0, 1, 1, 0, 1, 0, 0, -100,  0, 620, 0, 0};

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; mv = tbl[i].mv; bl = tbl[i].bl; br = tbl[i].br;
      bait = tbl[i].bait; bite = tbl[i].bite; tick = tbl[i].tick;
      dy = 9'(tbl[i].dy);
      cycle();
      chk($sformatf("tbl%0d_mode", i), int'(bus.mode), tbl[i].e_mode);
      chk($sformatf("tbl%0d_v", i), int'(bus.mouse_v), tbl[i].e_v);
      chk($sformatf("tbl%0d_bait_used", i), int'(bus.bait_used), tbl[i].e_bu);
      chk($sformatf("tbl%0d_caught", i), int'(bus.caught), tbl[i].e_ca);
    end

    // Cast and track down to the bottom clamp.
    quiet(); rst = 1'b1; cycle();
    quiet(); bl = 1'b1; cycle();
    quiet(); mv = 1'b1; dy = -9'sd100; cycle();
    chk("cast_mode", int'(bus.mode), 1);
    chk("cast_v", int'(bus.mouse_v), 720);
    peak = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (int'(bus.mouse_v) > peak) peak = int'(bus.mouse_v);
    end
    chk("sat_peak", peak, 4700);
    chk("sat_v", int'(bus.mouse_v), 4700);

    // Upper clamp from 700.
    quiet(); rst = 1'b1; cycle();
    quiet(); bl = 1'b1; cycle();
    quiet(); mv = 1'b1; dy = -9'sd80; cycle();
    chk("pre_clamp_v", int'(bus.mouse_v), 700);
    dy = 9'sd255; cycle();
    chk("upper_clamp_v", int'(bus.mouse_v), 620);

    // Reel-in from 1000 with mouse and clicks ignored.
    goto_baited(1000);
    bite = 1'b1; cycle();
    chk("reel_enter_mode", int'(bus.mode), 3);
    chk("reel_enter_v", int'(bus.mouse_v), 1000);
    ev = 1000;
    for (int k = 0; k < 10; k++) begin
      quiet(); bl = 1'b1; mv = 1'b1; dy = -9'sd100; cycle();
      chk("reel_ignore_mode", int'(bus.mode), 3);
      chk("reel_ignore_v", int'(bus.mouse_v), ev);
      ev = (ev - 40 < 620) ? 620 : ev - 40;
      quiet(); tick = 1'b1; cycle();
      chk($sformatf("reel_step%0d_v", k), int'(bus.mouse_v), ev);
      chk("reel_step_caught", int'(bus.caught), 0);
    end
    quiet(); tick = 1'b1; cycle();
    chk("caught_pulse", int'(bus.caught), 1);
    chk("caught_mode", int'(bus.mode), 0);
    chk("caught_v", int'(bus.mouse_v), 620);
    quiet(); cycle();
    chk("caught_single", int'(bus.caught), 0);

    // Bite and left click together while baited.
    goto_baited(900);
    bite = 1'b1; bl = 1'b1; cycle();
    chk("bite_vs_click_mode", int'(bus.mode), 3);

    // Left click with a packet in HOOK.
    quiet(); rst = 1'b1; cycle();
    quiet(); bl = 1'b1; cycle();
    quiet(); mv = 1'b1; dy = -9'sd200; cycle();
    bl = 1'b1; cycle();
    chk("click_pkt_mode", int'(bus.mode), 0);
    chk("click_pkt_v", int'(bus.mouse_v), 620);

    // Reset during a reel at 2000.
    goto_baited(2000);
    bite = 1'b1; cycle();
    chk("pre_rst_mode", int'(bus.mode), 3);
    quiet(); rst = 1'b1; tick = 1'b1; cycle();
    chk("rst_reel_mode", int'(bus.mode), 0);
    chk("rst_reel_v", int'(bus.mouse_v), 620);
    chk("rst_reel_caught", int'(bus.caught), 0);

    // Randomized run against the model.
    quiet();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 5) == 0) bl = ~bl;
      if ($urandom_range(0, 5) == 0) br = ~br;
      bait = ($urandom_range(0, 2) != 0);
      bite = ($urandom_range(0, 9) == 0);
      tick = ($urandom_range(0, 4) == 0);
      mv   = ($urandom_range(0, 1) == 1);
      dy   = 9'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
